vga_timing_gen: RTL and testbench

Parametrised VGA timing generator and output stage for the Connect-4 display path. It derives a pixel-clock enable from the system clock and counts horizontal and vertical position. It hands pixel coordinates to the board renderer, re-aligns the sync signals to the renderer's pipeline latency, and drives blanked RGB to the DAC pins. It replaces the fixed 640x480, 3-3-2 timing logic with configurable timing, polarity, colour depth and renderer latency.

---
 rtl/vga_pkg.sv | 16 +
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_delay.sv | 27 ++
 rtl/vga_timing_gen.sv | 86 ++++++++
 tb/tb_vga_timing_gen.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, sync polarity constants and counter-width helper.
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam bit SYNC_ACTIVE_LOW = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: coordinate/colour bus between the timing generator and the board renderer.
interface vga_timing_gen_if #(
  parameter int XW = 10,
  parameter int YW = 10,
  parameter int R_W = 3,
  parameter int G_W = 3,
  parameter int B_W = 2
);
  logic pix_ce;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic de_req;
  logic frame_start;
  logic [R_W-1:0] rnd_R;
  logic [G_W-1:0] rnd_G;
  logic [B_W-1:0] rnd_B;
  modport master(output pix_ce, x, y, de_req, frame_start, input rnd_R, rnd_G, rnd_B);
  modport slave(input pix_ce, x, y, de_req, frame_start, output rnd_R, rnd_G, rnd_B);
endinterface

// File: rtl/vga_delay.sv
// vga_delay: WIDTH x DEPTH shift register with clock enable and sync clear; wire when DEPTH=0.
module vga_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, ce};
    assign q = d;
  end else begin : g_sr
    logic [WIDTH-1:0] sr [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) sr <= '{default: '0};
      else if (ce) begin
        for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
        sr[0] <= d;
      end
    end
    assign q = sr[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel-enable divider, h/v counters, renderer-latency alignment and blanked pin registers.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit HS_POL = SYNC_ACTIVE_LOW,
  parameter bit VS_POL = SYNC_ACTIVE_LOW,
  parameter int CLK_DIV = 2,
  parameter int PIPE = 1,
  parameter int R_W = 3,
  parameter int G_W = 3,
  parameter int B_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  vga_timing_gen_if.master rb,
  output logic           vga_h_sync,
  output logic           vga_v_sync,
  output logic [R_W-1:0] vga_R,
  output logic [G_W-1:0] vga_G,
  output logic [B_W-1:0] vga_B
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = cnt_w(H_TOTAL);
  localparam int YW = cnt_w(V_TOTAL);
  localparam int DW = cnt_w(CLK_DIV);
  logic [DW-1:0] div_cnt;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic pix_ce, h_wrap, v_wrap, de_raw, hs_raw, vs_raw, de_d, hs_d, vs_d;
  assign pix_ce = !rst && int'(div_cnt) == CLK_DIV - 1;
  assign h_wrap = int'(h_cnt) == H_TOTAL - 1;
  assign v_wrap = int'(v_cnt) == V_TOTAL - 1;
  assign de_raw = int'(h_cnt) < H_ACTIVE && int'(v_cnt) < V_ACTIVE;
  assign hs_raw = int'(h_cnt) >= H_ACTIVE + H_FP && int'(h_cnt) < H_ACTIVE + H_FP + H_SYNC;
  assign vs_raw = int'(v_cnt) >= V_ACTIVE + V_FP && int'(v_cnt) < V_ACTIVE + V_FP + V_SYNC;
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
      if (pix_ce) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
        if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end
    end
  end
  // Raw timing is delayed to match the renderer so syncs and colour leave on the same edge.
  vga_delay #(.WIDTH(3), .DEPTH(PIPE)) u_delay (
    .clk(clk),
    .rst(rst),
    .ce(pix_ce),
    .d({de_raw, hs_raw, vs_raw}),
    .q({de_d, hs_d, vs_d})
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_h_sync <= ~HS_POL;
      vga_v_sync <= ~VS_POL;
      vga_R <= '0;
      vga_G <= '0;
      vga_B <= '0;
    end else if (pix_ce) begin
      vga_h_sync <= hs_d ? HS_POL : ~HS_POL;
      vga_v_sync <= vs_d ? VS_POL : ~VS_POL;
      vga_R <= de_d ? rb.rnd_R : '0;
      vga_G <= de_d ? rb.rnd_G : '0;
      vga_B <= de_d ? rb.rnd_B : '0;
    end
  end
  assign rb.pix_ce = pix_ce;
  assign rb.x = h_cnt;
  assign rb.y = v_cnt;
  assign rb.de_req = de_raw;
  assign rb.frame_start = pix_ce && h_cnt == '0 && v_cnt == '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: five configurations checked every clk against a tick-count reference model.
module tb_vga_timing_gen;
  import vga_pkg::*;
  localparam int N = 5;
  localparam int HA [N] = '{8, 8, 8, 8, 640};
  localparam int HF [N] = '{2, 2, 2, 2, 16};
  localparam int HSY [N] = '{3, 3, 3, 3, 96};
  localparam int HB [N] = '{2, 2, 2, 2, 48};
  localparam int VA [N] = '{4, 4, 4, 4, 480};
  localparam int VF [N] = '{1, 1, 1, 1, 10};
  localparam int VSY [N] = '{2, 2, 2, 2, 2};
  localparam int VB [N] = '{1, 1, 1, 1, 33};
  localparam int CD [N] = '{1, 3, 3, 2, 2};
  localparam int PP [N] = '{2, 0, 4, 1, 1};
  localparam int HP [N] = '{0, 0, 0, 1, 0};
  localparam int VP [N] = '{0, 0, 0, 1, 0};
  logic clk = 1'b0;
  logic rst;
  logic [7:0] rnd [N];
  logic [32:0] obs [N];
  logic [7:0] tbl [4][120];
  logic [7:0] c4;
  int j [N];
  bit started = 1'b0;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int HT = HA[g] + HF[g] + HSY[g] + HB[g];
    localparam int VT = VA[g] + VF[g] + VSY[g] + VB[g];
    vga_timing_gen_if #(.XW(cnt_w(HT)), .YW(cnt_w(VT))) ifc ();
    logic hs, vs;
    logic [2:0] r, gr;
    logic [1:0] b;
    vga_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HSY[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VSY[g]), .V_BP(VB[g]),
      .HS_POL(HP[g] != 0), .VS_POL(VP[g] != 0), .CLK_DIV(CD[g]), .PIPE(PP[g]),
      .R_W(3), .G_W(3), .B_W(2)
    ) dut (
      .clk(clk), .rst(rst), .rb(ifc),
      .vga_h_sync(hs), .vga_v_sync(vs), .vga_R(r), .vga_G(gr), .vga_B(b)
    );
    assign ifc.rnd_R = rnd[g][7:5];
    assign ifc.rnd_G = rnd[g][4:2];
    assign ifc.rnd_B = rnd[g][1:0];
    assign obs[g] = {ifc.pix_ce, 10'(ifc.x), 10'(ifc.y), ifc.de_req, ifc.frame_start, hs, vs, r, gr, b};
  end
  function automatic int htot(input int g);
    return HA[g] + HF[g] + HSY[g] + HB[g];
  endfunction
  function automatic int vtot(input int g);
    return VA[g] + VF[g] + VSY[g] + VB[g];
  endfunction
  function automatic logic [7:0] colour(input int g, input int p);
    return (g == 4) ? c4 : tbl[g][p];
  endfunction
  // Expected observation after j clocks since reset release: tick m = j/CLK_DIV, pins show position m-PIPE-1.
  function automatic logic [32:0] model(input int g, input int jj, input logic r);
    int ht, vt, fr, m, p, q, xx, yy, qx, qy;
    logic ce, de, fs, hs, vs, in_hs, in_vs;
    logic [7:0] c;
    ht = htot(g);
    vt = vtot(g);
    fr = ht * vt;
    m = jj / CD[g];
    ce = !r && ((jj + 1) % CD[g] == 0);
    p = m % fr;
    xx = p % ht;
    yy = p / ht;
    de = xx < HA[g] && yy < VA[g];
    fs = ce && p == 0;
    hs = HP[g] == 0;
    vs = VP[g] == 0;
    c = 8'h00;
    if (m >= PP[g] + 1) begin
      q = (m - PP[g] - 1) % fr;
      qx = q % ht;
      qy = q / ht;
      in_hs = qx >= HA[g] + HF[g] && qx < HA[g] + HF[g] + HSY[g];
      in_vs = qy >= VA[g] + VF[g] && qy < VA[g] + VF[g] + VSY[g];
      hs = (HP[g] != 0) ? in_hs : !in_hs;
      vs = (VP[g] != 0) ? in_vs : !in_vs;
      c = (qx < HA[g] && qy < VA[g]) ? colour(g, q) : 8'h00;
    end
    return {ce, 10'(xx), 10'(yy), de, fs, hs, vs, c};
  endfunction
  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
    end
  endtask
  // Tick bookkeeping and renderer: colour for position m-PIPE while tick count is m.
  always @(posedge clk) begin
    for (int g = 0; g < N; g++) j[g] = rst ? 0 : j[g] + 1;
    if (rst) started = 1'b1;
    #1;
    for (int g = 0; g < N; g++) begin
      int m;
      m = j[g] / CD[g];
      rnd[g] = (m >= PP[g]) ? colour(g, (m - PP[g]) % (htot(g) * vtot(g))) : 8'($urandom);
    end
  end
  always @(negedge clk) begin
    if (started)
      for (int g = 0; g < N; g++) check($sformatf("u%0d", g), obs[g], model(g, j[g], rst));
  end
  initial begin
    bit found;
    rst = 1'b0;
    for (int g = 0; g < N; g++) rnd[g] = 8'h00;
    c4 = 8'($urandom);
    for (int q = 0; q < 120; q++) begin
      tbl[0][q] = {3'(q % 15), 5'($urandom)};
      tbl[1][q] = 8'($urandom);
      tbl[2][q] = tbl[1][q];
      tbl[3][q] = 8'($urandom);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat ($urandom_range(3000, 4000)) @(posedge clk);
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      found = obs[0][31:22] == 10'd5 && obs[0][21:12] == 10'd3;
    end
    check("seek_mid_frame", 33'(found), 33'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (6000) @(posedge clk);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
